booth_mul_unit: RTL and testbench



---
 rtl/booth_mul_unit.sv | 93 +++++++++
 tb/tb_booth_mul_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_unit.sv
// Radix-2 Booth multiplier with its own controller and a start/busy/done handshake.
// Signed and unsigned operands share one signed engine by extending to N+1 bits at load.
module booth_mul_unit #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           signed_mode,
   input  logic [N-1:0]   m_in_1,
   input  logic [N-1:0]   m_in_2,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int W  = N + 1;
   localparam int CW = $clog2(N + 2);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state;
   logic [W-1:0]   a, q, m;
   logic           qm;
   logic [CW-1:0]  count;

   logic [W-1:0]   m_ext, q_ext;
   logic [W-1:0]   t, a_nxt, q_nxt;

   always_comb begin
      m_ext = signed_mode ? {m_in_1[N-1], m_in_1} : {1'b0, m_in_1};
      q_ext = signed_mode ? {m_in_2[N-1], m_in_2} : {1'b0, m_in_2};
   end

   // One Booth step: add/sub on the {Q0,Qm} pair, then arithmetic shift of {T,Q,Qm}.
   always_comb begin
      case ({q[0], qm})
         2'b10:   t = a - m;
         2'b01:   t = a + m;
         default: t = a;
      endcase
      a_nxt = {t[W-1], t[W-1:1]};
      q_nxt = {t[0], q[W-1:1]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         a       <= '0;
         q       <= '0;
         m       <= '0;
         qm      <= 1'b0;
         count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  m     <= m_ext;
                  q     <= q_ext;
                  a     <= '0;
                  qm    <= 1'b0;
                  count <= CW'(W);
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               a     <= a_nxt;
               q     <= q_nxt;
               qm    <= q[0];
               count <= count - 1'b1;
               // Low 2N bits of the 2W-bit result are exact in both modes.
               if (count == CW'(1)) begin
                  product <= {a_nxt[W-3:0], q_nxt};
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mul_unit.sv
// Bench for booth_mul_unit: N=8 and N=16 instances checked every cycle against an
// operation-lifetime model, plus directed literal products and a randomised N=16 sweep.
module tb_booth_mul_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start8 = 1'b0, sm8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8;
   logic [15:0] product8;

   logic        start16 = 1'b0, sm16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16;
   logic [31:0] product16;

   booth_mul_unit #(.N(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
      .m_in_1(a8), .m_in_2(b8), .busy(busy8), .done(done8), .product(product8));

   booth_mul_unit #(.N(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
      .m_in_1(a16), .m_in_2(b16), .busy(busy16), .done(done16), .product(product16));

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // True product of the operands as integers, reduced to 2n bits.
   function automatic longint ref_prod(input longint x, input longint y, input bit s, input int n);
      longint xv = x, yv = y, r;
      if (s) begin
         if (x[n-1]) xv = x - (longint'(1) << n);
         if (y[n-1]) yv = y - (longint'(1) << n);
      end
      r = xv * yv;
      return r & ((longint'(1) << (2 * n)) - 1);
   endfunction

   // Model: an accepted operation lives N+2 edges; done on its last one, busy throughout.
   int     l8 = 0, l16 = 0;
   longint p8 = 0, p16 = 0, pend8 = 0, pend16 = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         l8 = 0; p8 = 0; l16 = 0; p16 = 0;
      end else begin
         if (l8 > 0) begin
            l8--;
            if (l8 == 1) p8 = pend8;
         end else if (start8) begin
            l8 = 10;
            pend8 = ref_prod(longint'(a8), longint'(b8), sm8, 8);
         end
         if (l16 > 0) begin
            l16--;
            if (l16 == 1) p16 = pend16;
         end else if (start16) begin
            l16 = 18;
            pend16 = ref_prod(longint'(a16), longint'(b16), sm16, 16);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy8",  64'(busy8),     64'(l8 > 0));
         chk("done8",  64'(done8),     64'(l8 == 1));
         chk("prod8",  64'(product8),  64'(p8));
         chk("busy16", 64'(busy16),    64'(l16 > 0));
         chk("done16", 64'(done16),    64'(l16 == 1));
         chk("prod16", 64'(product16), 64'(p16));
      end
   end

   task automatic op8(input logic [7:0] x, input logic [7:0] y, input bit s,
                      input logic [15:0] exp, input string nm);
      int n;
      @(negedge clk);
      start8 = 1'b1; a8 = x; b8 = y; sm8 = s;
      @(negedge clk);
      start8 = 1'b0; a8 = ~x; b8 = ~y; sm8 = ~s;
      n = 1;
      while (!done8 && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 5) start8 = 1'b1;
         if (n == 6) start8 = 1'b0;
      end
      chk({nm, "_latency"}, 64'(n), 64'd10);
      chk({nm, "_product"}, 64'(product8), 64'(exp));
   endtask

   task automatic op16(input logic [15:0] x, input logic [15:0] y, input bit s, input string nm);
      int n;
      longint e;
      e = ref_prod(longint'(x), longint'(y), s, 16);
      @(negedge clk);
      start16 = 1'b1; a16 = x; b16 = y; sm16 = s;
      @(negedge clk);
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      n = 1;
      while (!done16 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_latency"}, 64'(n), 64'd18);
      chk({nm, "_product"}, 64'(product16), 64'(e));
   endtask

   initial begin
      int dn;
      repeat (2) @(negedge clk);
      chk("rst_busy8", 64'(busy8), 64'd0);
      chk("rst_done8", 64'(done8), 64'd0);
      chk("rst_prod8", 64'(product8), 64'd0);
      chk("rst_prod16", 64'(product16), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk_en = 1'b1;

      op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "umax");
      op8(8'h80, 8'h80, 1'b1, 16'h4000, "smin_sq");
      op8(8'hFF, 8'h7F, 1'b1, 16'hFF81, "neg1_x_127");
      op8(8'h00, 8'hA5, 1'b1, 16'h0000, "zero");
      op8(8'hFF, 8'h02, 1'b0, 16'h01FE, "mode_u");
      op8(8'hFF, 8'h02, 1'b1, 16'hFFFE, "mode_s");

      // Start held high with operands churning: one operation every 11 cycles.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'd3; b8 = 8'd5; sm8 = 1'b0;
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done8) dn++;
         a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
      end
      chk("held_start_dones", 64'(dn), 64'd3);
      start8 = 1'b0;
      repeat (12) @(negedge clk);

      // Reset asserted during the fourth RUN cycle discards the operation.
      start8 = 1'b1; a8 = 8'd9; b8 = 8'd9; sm8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 64'(busy8), 64'd0);
      chk("midrst_done", 64'(done8), 64'd0);
      chk("midrst_prod", 64'(product8), 64'd0);
      rst_n = 1'b1;
      dn = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done8) dn++;
      end
      chk("midrst_no_done", 64'(dn), 64'd0);
      op8(8'd7, 8'd6, 1'b0, 16'h002A, "after_rst");

      op16(16'h8000, 16'h8000, 1'b1, "w16_smin");
      op16(16'hFFFF, 16'hFFFF, 1'b0, "w16_umax");
      for (int i = 0; i < 1000; i++)
         op16(16'($urandom), 16'($urandom), 1'($urandom), "w16_rand");

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
